// File: rtl/am_tx_modulator.sv
// AM transmit modulator: NCO carrier, cosine LUT x audio envelope,
// first-order sigma-delta to a 1-bit RF bitstream.
module am_tx_modulator #(
    parameter int SAMPLE_DIV = 64
) (
    input  logic        clk,
    input  logic        RSTb,
    input  logic        tx_en,
    input  logic [15:0] phase_inc,
    input  logic [7:0]  audio_in,
    input  logic        audio_valid,
    output logic        audio_ready,
    output logic        underrun,
    output logic        RF_OUT
);

    localparam int DW = $clog2(SAMPLE_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    logic [15:0]        nco_phase;
    logic signed [3:0]  cos_reg;
    logic signed [3:0]  cos_lut;
    logic signed [11:0] prod;
    logic signed [12:0] acc;
    logic signed [12:0] mult;
    logic signed [12:0] fb;
    logic signed [12:0] acc_next;
    logic [7:0]         env;
    logic [7:0]         hold_reg;
    logic               hold_full;
    logic [DW-1:0]      div_cnt;
    logic               strobe;
    logic               accept;
    logic               y;

    assign audio_ready = !hold_full;
    assign accept      = audio_valid && !hold_full;
    assign strobe      = tx_en && (div_cnt == DIV_LAST);

    always_comb begin
        cos_lut = '0;
        unique case (nco_phase[15:12])
            4'd0:  cos_lut = 4'sh7;
            4'd1:  cos_lut = 4'sh7;
            4'd2:  cos_lut = 4'sh5;
            4'd3:  cos_lut = 4'sh3;
            4'd4:  cos_lut = 4'sh0;
            4'd5:  cos_lut = 4'shD;
            4'd6:  cos_lut = 4'shA;
            4'd7:  cos_lut = 4'sh8;
            4'd8:  cos_lut = 4'sh8;
            4'd9:  cos_lut = 4'sh8;
            4'd10: cos_lut = 4'shA;
            4'd11: cos_lut = 4'shD;
            4'd12: cos_lut = 4'sh0;
            4'd13: cos_lut = 4'sh3;
            4'd14: cos_lut = 4'sh5;
            4'd15: cos_lut = 4'sh7;
        endcase
    end

    // Envelope is unsigned, so zero-extend before the signed multiply
    assign mult     = cos_reg * $signed({5'b0, env});
    assign y        = !acc[12];
    assign fb       = y ? 13'sd2048 : -13'sd2048;
    assign acc_next = acc + $signed({prod[11], prod}) - fb;

    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            env       <= 8'd128;
            underrun  <= 1'b0;
        end else begin
            if (accept) begin
                hold_reg  <= audio_in;
                hold_full <= 1'b1;
            end
            underrun <= strobe && !hold_full;
            if (strobe && hold_full) begin
                env       <= hold_reg ^ 8'h80;
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            nco_phase <= '0;
            cos_reg   <= '0;
            prod      <= '0;
            acc       <= '0;
            RF_OUT    <= 1'b0;
            div_cnt   <= '0;
        end else if (!tx_en) begin
            nco_phase <= '0;
            cos_reg   <= '0;
            prod      <= '0;
            acc       <= '0;
            RF_OUT    <= 1'b0;
            div_cnt   <= '0;
        end else begin
            nco_phase <= nco_phase + phase_inc;
            cos_reg   <= cos_lut;
            prod      <= mult[11:0];
            acc       <= acc_next;
            RF_OUT    <= y;
            div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_am_tx_modulator.sv
// Directed bench for am_tx_modulator: carrier LUT, sigma-delta density,
// envelope handshake, underrun and reset behaviour.
module tb_am_tx_modulator;

    logic        clk = 1'b0;
    logic        RSTb = 1'b0;
    logic        tx_en = 1'b0;
    logic [15:0] phase_inc = '0;
    logic [7:0]  audio_in = '0;
    logic        audio_valid = 1'b0;
    logic        audio_ready;
    logic        underrun;
    logic        RF_OUT;

    int n_assert = 0;
    int n_fail = 0;
    int exp_q[$];
    int ur_cnt = 0;
    int ur_dbl = 0;
    int acc_cnt = 0;
    logic ur_prev = 1'b0;

    int lut[16] = '{7, 7, 5, 3, 0, -3, -6, -8, -8, -8, -6, -3, 0, 3, 5, 7};

    am_tx_modulator #(.SAMPLE_DIV(64)) dut (
        .clk(clk),
        .RSTb(RSTb),
        .tx_en(tx_en),
        .phase_inc(phase_inc),
        .audio_in(audio_in),
        .audio_valid(audio_valid),
        .audio_ready(audio_ready),
        .underrun(underrun),
        .RF_OUT(RF_OUT)
    );

    always #5 clk = ~clk;

    // Values read here are those held during the cycle that just ended
    always @(posedge clk) begin
        if (underrun) ur_cnt++;
        if (underrun && ur_prev) ur_dbl++;
        ur_prev = underrun;
        if (audio_valid && audio_ready) acc_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int exp);
        exp_q.push_back(exp);
    endtask

    task automatic pop_chk(input string tag, input int obs, input int tol);
        int e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            n_assert++;
            assert (((obs >= e - tol) && (obs <= e + tol)) === 1'b1) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d +-%0d",
                       tag, obs, e, tol);
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (audio_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (audio_ready !== 1'b1) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic send(input logic [7:0] s);
        audio_in = s;
        audio_valid = 1'b1;
        wait_ready("send");
        @(negedge clk);
        audio_valid = 1'b0;
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(RF_OUT);
        end
    endtask

    task automatic wait_underrun(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (underrun === 1'b1) break;
        end
    endtask

    initial begin
        int ones;
        int n;
        int bad;
        int u0;
        int a0;
        logic prev;
        logic [7:0] hs[3];

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rf", int'(RF_OUT), 0);
        chk("rst_ready", int'(audio_ready), 1);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_env", int'(dut.env), 128);
        RSTb = 1'b1;
        @(negedge clk);

        // Carrier: phase_inc 0x1000 walks the LUT once per 16 cycles
        phase_inc = 16'h1000;
        tx_en = 1'b1;
        bad = 0;
        for (int i = 1; i <= 48; i++) begin
            @(negedge clk);
            if (int'(dut.cos_reg) !== lut[(i - 1) % 16]) bad++;
        end
        chk("cos_seq_wrap", bad, 0);
        push(2008);
        count_ones(4096, ones);
        pop_chk("carrier_ones", ones, 2);

        // DC carrier, no audio: first strobe 64 cycles after enable
        tx_en = 1'b0;
        @(negedge clk);
        phase_inc = 16'h0000;
        tx_en = 1'b1;
        wait_underrun(n);
        chk("first_strobe", n, 64);
        u0 = ur_cnt;
        push(2944);
        count_ones(4096, ones);
        pop_chk("dc_ones", ones, 1);
        chk("dc_underruns", ur_cnt - u0, 64);
        chk("underrun_width", ur_dbl, 0);
        chk("dc_prod", int'(dut.prod), 896);

        // Zero envelope: audio -128
        push(0);
        send(8'h80);
        wait_ready("zero_consume");
        pop_chk("zero_env", int'(dut.env), 0);
        repeat (8) @(negedge clk);
        prev = RF_OUT;
        bad = 0;
        repeat (32) begin
            @(negedge clk);
            if (RF_OUT === prev) bad++;
            prev = RF_OUT;
        end
        chk("zero_alternate", bad, 0);

        // Full envelope: audio 127
        push(255);
        send(8'h7F);
        wait_ready("full_consume");
        pop_chk("full_env", int'(dut.env), 0);
        repeat (16) @(negedge clk);
        chk("full_prod", int'(dut.prod), 1785);
        push(3833);
        count_ones(4096, ones);
        pop_chk("full_ones", ones, 1);

        // Handshake: valid held high across three samples
        hs[0] = 8'h10;
        hs[1] = 8'hF0;
        hs[2] = 8'h55;
        u0 = ur_cnt;
        a0 = acc_cnt;
        audio_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            audio_in = hs[k];
            wait_ready("hs_ready");
            if (k > 0) pop_chk("hs_env", int'(dut.env), 0);
            push(int'(hs[k] ^ 8'h80));
            @(negedge clk);
            chk("hs_ready_low", int'(audio_ready), 0);
        end
        audio_valid = 1'b0;
        wait_ready("hs_last");
        pop_chk("hs_env_last", int'(dut.env), 0);
        chk("hs_no_underrun", ur_cnt - u0, 0);
        chk("hs_accepts", acc_cnt - a0, 3);
        wait_underrun(n);
        chk("hs_underrun_at", n, 64);
        push(int'(8'hD5));
        pop_chk("hs_env_hold", int'(dut.env), 0);

        // Reset mid-stream with a sample pending
        send(8'h33);
        chk("pend_ready", int'(audio_ready), 0);
        #2;
        RSTb = 1'b0;
        #1;
        chk("mid_rst_rf", int'(RF_OUT), 0);
        chk("mid_rst_ready", int'(audio_ready), 1);
        chk("mid_rst_underrun", int'(underrun), 0);
        chk("mid_rst_env", int'(dut.env), 128);
        tx_en = 1'b0;
        @(negedge clk);
        RSTb = 1'b1;
        u0 = ur_cnt;
        count_ones(32, ones);
        chk("idle_rf", ones, 0);

        // Disabled: one sample accepted, never consumed
        send(8'h22);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (audio_ready !== 1'b0) bad++;
        end
        chk("idle_hold", bad, 0);
        chk("idle_env", int'(dut.env), 128);
        chk("idle_underrun", ur_cnt - u0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
